// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target with a 4-register CPU window and level irq.
// Define SPI_TARGET_FIFO_EN to replace the RX holding register with a 4-entry FIFO.
`timescale 1ns/1ps
module spi_target #(
    parameter logic [7:0] RESET_TX = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       sck,
    input  logic       mosi,
    input  logic       ss_n,
    output logic       miso,
    output logic       miso_oe
);
    logic [2:0] sck_sy;
    logic [2:0] ss_sy;
    logic [1:0] mosi_sy;
    logic       rise_q;
    logic       fall_q;
    logic       sfall_q;
    logic       mosi_q;

    logic       en;
    logic       rxie;
    logic       txie;
    logic [7:0] txh;
    logic       txe;
    logic       ovr;
    logic       udr;
    logic [7:0] sr;
    logic [2:0] cnt;
    logic       done;

    logic       sel;
    logic       wr_cyc;
    logic       rd_cyc;
    logic       data_wr;
    logic       data_rd;
    logic       ctrl_wr;
    logic       clr_wr;
    logic       rx_done;
    logic       tx_load;
    logic [7:0] rx_byte;
    logic       rxf;
    logic [7:0] rx_data;
    logic       ovr_set;
    logic [1:0] fifo_lvl;

    // sync stage 2 vs stage 3 finds the edge; the event is then registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sy  <= '0;
            ss_sy   <= '1;
            mosi_sy <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            sfall_q <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            sck_sy  <= {sck_sy[1:0], sck};
            ss_sy   <= {ss_sy[1:0], ss_n};
            mosi_sy <= {mosi_sy[0], mosi};
            rise_q  <= sck_sy[1] & ~sck_sy[2];
            fall_q  <= ~sck_sy[1] & sck_sy[2];
            sfall_q <= ~ss_sy[1] & ss_sy[2];
            mosi_q  <= mosi_sy[1];
        end
    end

    assign sel     = en & ~ss_sy[1];
    assign wr_cyc  = cs & ~rw;
    assign rd_cyc  = cs & rw;
    assign data_wr = wr_cyc & (AD == 2'd0);
    assign ctrl_wr = wr_cyc & (AD == 2'd2);
    assign clr_wr  = wr_cyc & (AD == 2'd3);
    assign data_rd = rd_cyc & (AD == 2'd0);
    assign rx_done = sel & rise_q & (cnt == 3'd7);
    assign tx_load = sel & (sfall_q | (fall_q & done));
    assign rx_byte = {sr[6:0], mosi_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= RESET_TX;
            cnt  <= '0;
            done <= 1'b0;
            txh  <= '0;
            txe  <= 1'b1;
            udr  <= 1'b0;
        end else begin
            if (data_wr)
                txh <= DI;
            if (!sel) begin
                cnt  <= '0;
                done <= 1'b0;
            end else if (tx_load) begin
                sr   <= data_wr ? DI : (txe ? RESET_TX : txh);
                cnt  <= '0;
                done <= 1'b0;
            end else if (rise_q) begin
                sr   <= rx_byte;
                cnt  <= cnt + 3'd1;
                done <= (cnt == 3'd7);
            end
            // a same-cycle CPU write feeds the load directly, so TXE stays set
            if (tx_load)
                txe <= 1'b1;
            else if (data_wr)
                txe <= 1'b0;
            udr <= (udr & ~(clr_wr & DI[3])) | (tx_load & ~data_wr & txe);
        end
    end

`ifdef SPI_TARGET_FIFO_EN
    logic [7:0] mem [4];
    logic [1:0] wp;
    logic [1:0] rp;
    logic [2:0] fcnt;
    logic       push;
    logic       pop;

    assign pop  = data_rd & (fcnt != 3'd0);
    assign push = rx_done & ((fcnt != 3'd4) | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                mem[i] <= '0;
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            if (push) begin
                mem[wp] <= rx_byte;
                wp      <= wp + 2'd1;
            end
            if (pop)
                rp <= rp + 2'd1;
            fcnt <= fcnt + {2'b00, push} - {2'b00, pop};
        end
    end

    assign rxf      = (fcnt != 3'd0);
    assign rx_data  = mem[rp];
    assign ovr_set  = rx_done & ~push;
    assign fifo_lvl = fcnt[2] ? 2'b11 : fcnt[1:0];
`else
    logic [7:0] rxd;
    logic       rxf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd   <= '0;
            rxf_q <= 1'b0;
        end else if (rx_done && (data_rd || !rxf_q)) begin
            rxd   <= rx_byte;
            rxf_q <= 1'b1;
        end else if (data_rd) begin
            rxf_q <= 1'b0;
        end
    end

    assign rxf      = rxf_q;
    assign rx_data  = rxd;
    assign ovr_set  = rx_done & rxf_q & ~data_rd;
    assign fifo_lvl = 2'b00;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en   <= 1'b0;
            rxie <= 1'b0;
            txie <= 1'b0;
            ovr  <= 1'b0;
            irq  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en   <= DI[7];
                txie <= DI[1];
                rxie <= DI[0];
            end
            ovr <= (ovr & ~(clr_wr & DI[2])) | ovr_set;
            irq <= (rxf & rxie) | (ovr & rxie) | (txe & txie);
        end
    end

    always_comb begin
        DO = '0;
        unique case (AD)
            2'd0:    DO = rx_data;
            2'd1:    DO = {irq, fifo_lvl, ~ss_sy[1], udr, ovr, txe, rxf};
            2'd2:    DO = {en, 5'b00000, txie, rxie};
            default: DO = '0;
        endcase
    end

    assign miso    = sr[7];
    assign miso_oe = sel;

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: bus reads and miso bits are queued
// with expected values and checked by independent monitors.
`timescale 1ns/1ps
module tb_spi_target;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] AD = 2'd0;
    logic [7:0] DI = 8'h00;
    logic [7:0] DO;
    logic       rw = 1'b1;
    logic       cs = 1'b0;
    logic       irq;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       ss_n = 1'b1;
    logic       miso;
    logic       miso_oe;

    spi_target dut (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO),
        .rw(rw), .cs(cs), .irq(irq), .sck(sck), .mosi(mosi),
        .ss_n(ss_n), .miso(miso), .miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    // observed word is {miso, irq, miso_oe, DO}
    localparam logic [10:0] ALL    = 11'h7FF;
    localparam logic [10:0] NOMISO = 11'h3FF;

    logic [10:0] rv[$];
    logic [10:0] rm[$];
    string       rn[$];
    logic        mq[$];
    int          tests = 0;
    int          fails = 0;

    always @(negedge clk) begin
        if (cs && rw) begin
            logic [10:0] act;
            logic [10:0] v;
            logic [10:0] m;
            string       nm;
            act = {miso, irq, miso_oe, DO};
            tests++;
            if (rv.size() == 0) begin
                fails++;
                $display("FAIL unexpected_read: got %h want none", act);
            end else begin
                v  = rv.pop_front();
                m  = rm.pop_front();
                nm = rn.pop_front();
                if ((act & m) !== (v & m)) begin
                    fails++;
                    $display("FAIL %s: got %h want %h", nm, act & m, v & m);
                end
            end
        end
    end

    always @(posedge sck) begin
        if (mq.size() != 0) begin
            logic e;
            e = mq.pop_front();
            tests++;
            if (miso !== e) begin
                fails++;
                $display("FAIL miso_bit: got %b want %b", miso, e);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [10:0] v,
                      input logic [10:0] m, input string nm);
        rv.push_back(v);
        rm.push_back(m);
        rn.push_back(nm);
        AD = a;
        rw = 1'b1;
        cs = 1'b1;
        tick(1);
        cs = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        AD = a;
        DI = d;
        rw = 1'b0;
        cs = 1'b1;
        tick(1);
        cs = 1'b0;
        rw = 1'b1;
    endtask

    // mode-0 master, 5 clk per phase; hold leaves sck high after the last rise
    task automatic frame(input logic [7:0] m, input int nbits, input bit hold,
                         input bit chk, input logic [7:0] exp);
        for (int i = 0; i < nbits; i++) begin
            mosi = m[7-i];
            if (chk)
                mq.push_back(exp[7-i]);
            tick(5);
            sck = 1'b1;
            if (!(hold && i == nbits - 1)) begin
                tick(5);
                sck = 1'b0;
            end
        end
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);

        rd(2'd1, {3'b100, 8'h02}, ALL, "rst_status");
        rd(2'd2, {3'b100, 8'h00}, ALL, "rst_ctrl");

        wr(2'd2, 8'h80);
        wr(2'd0, 8'hA5);
        rd(2'd1, {3'b100, 8'h00}, ALL, "txh_loaded");
        ss_n = 1'b0;
        tick(6);
        rd(2'd1, {3'b101, 8'h12}, ALL, "sel_status");
        frame(8'h3C, 8, 1'b1, 1'b1, 8'hA5);
        tick(6);
        rd(2'd1, {3'b001, 8'h13}, NOMISO, "rx_status");
        rd(2'd0, {3'b001, 8'h3C}, NOMISO, "rx_data");
        sck = 1'b0;
        tick(6);
        rd(2'd1, {3'b101, 8'h1A}, ALL, "udr_status");

        frame(8'h11, 8, 1'b0, 1'b1, 8'hFF);
        frame(8'h22, 8, 1'b0, 1'b1, 8'hFF);
        tick(6);
`ifdef SPI_TARGET_FIFO_EN
        rd(2'd1, {3'b101, 8'h5B}, ALL, "two_status");
        rd(2'd0, {3'b101, 8'h11}, ALL, "fifo_first");
        rd(2'd0, {3'b101, 8'h22}, ALL, "fifo_second");
        rd(2'd1, {3'b101, 8'h1A}, ALL, "two_after");
`else
        rd(2'd1, {3'b101, 8'h1F}, ALL, "two_status");
        rd(2'd0, {3'b101, 8'h11}, ALL, "ovr_data");
        rd(2'd1, {3'b101, 8'h1E}, ALL, "two_after");
`endif
        wr(2'd3, 8'h0C);
        rd(2'd1, {3'b101, 8'h12}, ALL, "clr_status");

        frame(8'hF0, 5, 1'b0, 1'b0, 8'h00);
        ss_n = 1'b1;
        tick(6);
        rd(2'd1, {3'b000, 8'h02}, NOMISO, "partial_status");
        ss_n = 1'b0;
        tick(6);
        frame(8'h5A, 8, 1'b0, 1'b1, 8'hFF);
        tick(6);
`ifdef SPI_TARGET_FIFO_EN
        rd(2'd1, {3'b101, 8'h3B}, ALL, "one_byte_status");
`else
        rd(2'd1, {3'b101, 8'h1B}, ALL, "one_byte_status");
`endif
        rd(2'd0, {3'b101, 8'h5A}, ALL, "one_byte_data");
        rd(2'd1, {3'b101, 8'h1A}, ALL, "one_byte_after");

        wr(2'd3, 8'h0C);
        wr(2'd2, 8'h81);
        rd(2'd2, {3'b001, 8'h81}, NOMISO, "ctrl_rxie");
        frame(8'h96, 8, 1'b1, 1'b1, 8'hFF);
        tick(3);
        rd(2'd1, {3'b001, 8'h12}, NOMISO, "irq_pre");
        rd(2'd1, {3'b001, 8'h13}, NOMISO, "irq_rxf");
        rd(2'd1, {3'b011, 8'h93}, NOMISO, "irq_rise");
        rd(2'd0, {3'b011, 8'h96}, NOMISO, "irq_data");
        sck = 1'b0;
        tick(6);
        rd(2'd1, {3'b101, 8'h1A}, ALL, "irq_fall");

        frame(8'hC0, 4, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        rd(2'd1, {3'b100, 8'h02}, ALL, "rst_mid_status");
        rd(2'd2, {3'b100, 8'h00}, ALL, "rst_mid_ctrl");
        ss_n = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(6);
        rd(2'd1, {3'b100, 8'h02}, ALL, "post_rst");

        tick(4);
        tests++;
        if (rv.size() != 0 || mq.size() != 0) begin
            fails++;
            $display("FAIL queues_drained: got %0d/%0d left want 0/0",
                     rv.size(), mq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_target.md
# spi_target

SPI target (slave) peripheral for the 6801-class system bus: the responding end of the SPI link that the system's SPI master drives. An external master clocks bytes in on `mosi` and the block returns bytes on `miso`; the CPU exchanges data through a 4-register window with a single level interrupt. It decodes in one 32-byte I/O slot like the other bus peripherals and runs entirely on `clk`.

## Interface
- `RESET_TX`, 8'hFF, byte shifted out when the TX holding register is empty (underrun fill)
- `clk` in 1 system clock; every register samples on its rising edge
- `rst` in 1 asynchronous, active-high reset
- `AD` in 2 register select
- `DI` in 8 write data from CPU
- `DO` out 8 read data; combinational from `AD`
- `rw` in 1 1 = read, 0 = write
- `cs` in 1 select, already qualified with VMA
- `irq` out 1 level interrupt request, active high
- `sck` in 1 SPI clock from the external master; asynchronous to `clk`
- `mosi` in 1 serial data from the master
- `ss_n` in 1 target select, active low
- `miso` out 1 serial data to the master
- `miso_oe` out 1 high while `ss_n` is synchronised low and CTRL.EN = 1

## Operation
- SPI mode 0 only, MSB first, 8-bit frames.
- `sck`, `mosi`, `ss_n` each pass through a 2-flop synchroniser. Edge detection compares sync stage 2 against a third flop.
- Registers:
  - AD=0 DATA. Read returns the RX byte and, on the cycle's rising edge, clears RXF (pops the FIFO under the macro). Write loads TXH and clears TXE.
  - AD=1 STATUS (read-only): b0 RXF, b1 TXE, b2 OVR, b3 UDR, b4 SS (synchronised select active), b7 = `irq`.
  - AD=2 CTRL (R/W): b0 RXIE, b1 TXIE, b7 EN. Other bits read 0.
  - AD=3 CLR. A write clears OVR where DI[2]=1 and UDR where DI[3]=1. Reads return 0.
- Register writes occur when `cs` = 1 and `rw` = 0 at the rising edge of `clk`. Read side effects require `cs` = 1 and `rw` = 1.
- A select-falling event (ss falls while EN = 1) clears the bit counter and loads the shift register:
  - TXH, then TXE is set; or
  - `RESET_TX` if TXE = 1, and UDR is set.
- Rising `sck` (selected): shift `{sr[6:0], mosi}` and increment the 3-bit counter. On the 8th rising edge the counter wraps to 0:
  - if RXF = 0, the byte goes to RXD and RXF is set;
  - otherwise OVR is set and the byte is dropped.
- Falling `sck` after a completed byte: reload the shift register from TXH or `RESET_TX` by the same rule as select-falling.
- `miso` = sr[7] at all times.
- Select-rising mid-byte discards the partial byte. The counter returns to 0 and RXF, OVR and RXD are unchanged.
- EN = 0 ignores all SPI events and holds the counter at 0. Registers stay accessible.
- `irq` = (RXF & RXIE) | (OVR & RXIE) | (TXE & TXIE), registered.
- Simultaneous events:
  - CPU DATA read and byte completion in the same cycle: the new byte is stored, RXF stays 1, no OVR.
  - CPU DATA write and shift-register load in the same cycle: the load uses the new DI, and TXE stays 1.

## Timing
- Reset values: RXD=0, TXH=0, sr=`RESET_TX`, counter=0, RXF=0, TXE=1, OVR=0, UDR=0, CTRL=0, `irq`=0, `miso_oe`=0, `miso`=`RESET_TX`[7].
- Pin-to-event latency is 3 `clk` edges (2 synchroniser + 1 detect). RXF is visible at the 4th edge after the 8th `sck` rise; `irq` follows one edge later.
- The first bit is valid on `miso` 4 `clk` edges after `ss_n` falls.
- `sck` high and low phases must each be ≥ 4 `clk` periods, so maximum SPI rate is `clk`/8. `ss_n` setup to first `sck` rise must be ≥ 4 `clk` periods.
- DO is combinational. Register updates land at the rising edge that ends the bus cycle.
- Reset asserted mid-frame returns everything to reset values immediately, and `miso_oe` drops asynchronously.

## Configuration
- `SPI_TARGET_FIFO_EN` defined: RXD becomes a 4-entry RX FIFO with 2-bit read/write pointers and a 3-bit count.
  - RXF = count ≠ 0.
  - A DATA read pops one entry.
  - A byte arriving when count = 4 is dropped and sets OVR.
  - Pop and push in the same cycle leave count unchanged.
  - STATUS b6:b5 = count[1:0] when count < 4, and 2'b11 when full.
- Not defined: single holding register as described above; STATUS b6:b5 read 0.

## Test plan
- After reset: read STATUS -> 8'h02 and CTRL -> 8'h00. `miso_oe` = 0 and `irq` = 0.
- EN=1, TXH=8'hA5, then master sends 8'h3C at `clk`/8. Required: `miso` bits 1,0,1,0,0,1,0,1; DATA reads 8'h3C; STATUS shows RXF=1, TXE=1; UDR=0.
- Two frames 8'h11 then 8'h22 with no DATA read in between. Required: DATA reads 8'h11 and OVR=1. With `SPI_TARGET_FIFO_EN`: reads 8'h11 then 8'h22, OVR=0.
- Frame with TXE=1: `miso` shifts 8'hFF and UDR=1. A CLR write of 8'h0C clears UDR and OVR.
- `ss_n` rises after 5 `sck` edges, then a full frame 8'h5A follows. Required: exactly one byte received, 8'h5A.
- RXIE=1: `irq` rises one `clk` edge after RXF. Required: `irq` falls after the DATA read, and `rst` pulsed mid-frame returns all outputs to reset values.
